// File: rtl/i2c_slave.sv
// I2C responder for a single 7-bit address with a byte-wide rx/tx interface, oversampling SCL/SDA on clk.
// Optional build macro I2C_SLAVE_GENCALL_EN: also ACKs the general-call write address byte 8'h00.
module i2c_slave #(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h2D,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_req,
   output logic       busy,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR   = 3'd1,
      ST_ACK_A  = 3'd2,
      ST_RX     = 3'd3,
      ST_ACK_RX = 3'd4,
      ST_TX     = 3'd5,
      ST_ACK_TX = 3'd6
   } state_t;

   // Chains reset to the idle-bus level so reset never creates a phantom edge.
   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
         sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
      end
   end

   logic scl_s;
   logic sda_s;
   logic scl_rise;
   logic scl_fall;
   logic start_det;
   logic stop_det;

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & ~sda_prev_q & sda_s;

   state_t     state_q,    state_d;
   logic [2:0] bit_cnt_q,  bit_cnt_d;
   logic       full_q,     full_d;
   logic [7:0] shift_q,    shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic       rw_q,       rw_d;
   logic       ack_q,      ack_d;
   logic       sda_oe_q,   sda_oe_d;
   logic [7:0] rx_data_q,  rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_req_q,   tx_req_d;
   logic       busy_q,     busy_d;

   logic addr_hit;
`ifdef I2C_SLAVE_GENCALL_EN
   assign addr_hit = (shift_q[7:1] == SLAVE_ADDR) || (shift_q == 8'h00);
`else
   assign addr_hit = (shift_q[7:1] == SLAVE_ADDR);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         full_q     <= 1'b0;
         shift_q    <= 8'h00;
         tx_shift_q <= 8'h00;
         rw_q       <= 1'b0;
         ack_q      <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
         tx_req_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         full_q     <= full_d;
         shift_q    <= shift_d;
         tx_shift_q <= tx_shift_d;
         rw_q       <= rw_d;
         ack_q      <= ack_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_req_q   <= tx_req_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      full_d     = full_q;
      shift_d    = shift_q;
      tx_shift_d = tx_shift_q;
      rw_d       = rw_q;
      ack_d      = ack_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_req_d   = 1'b0;
      busy_d     = busy_q;

      if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 3'd0;
         full_d    = 1'b0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (stop_det) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         full_d    = 1'b0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else begin
         unique case (state_q)
            ST_ADDR, ST_RX: begin
               // full_q marks that 8 bits are in; the next SCL fall closes the byte.
               if (scl_rise && !full_q) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  full_d    = (bit_cnt_q == 3'd7);
               end else if (scl_fall && full_q) begin
                  full_d = 1'b0;
                  if (state_q == ST_ADDR) begin
                     if (addr_hit) begin
                        rw_d     = shift_q[0];
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ST_ACK_A;
                        if (shift_q[0]) begin
                           tx_shift_d = tx_data;
                           tx_req_d   = 1'b1;
                        end
                     end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_IDLE;
                     end
                  end else begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     sda_oe_d   = 1'b1;
                     state_d    = ST_ACK_RX;
                  end
               end
            end
            ST_ACK_A: begin
               if (scl_fall) begin
                  bit_cnt_d = 3'd0;
                  full_d    = 1'b0;
                  if (rw_q) begin
                     sda_oe_d = ~tx_shift_q[7];
                     state_d  = ST_TX;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_RX;
                  end
               end
            end
            ST_ACK_RX: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  state_d  = ST_RX;
               end
            end
            ST_TX: begin
               if (scl_rise && !full_q) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  full_d    = (bit_cnt_q == 3'd7);
               end else if (scl_fall) begin
                  if (full_q) begin
                     full_d   = 1'b0;
                     sda_oe_d = 1'b0;
                     state_d  = ST_ACK_TX;
                  end else begin
                     sda_oe_d   = ~tx_shift_q[6];
                     tx_shift_d = {tx_shift_q[6:0], 1'b0};
                  end
               end
            end
            ST_ACK_TX: begin
               if (scl_rise) begin
                  ack_d = sda_s;
               end else if (scl_fall) begin
                  if (!ack_q) begin
                     tx_shift_d = tx_data;
                     tx_req_d   = 1'b1;
                     sda_oe_d   = ~tx_data[7];
                     bit_cnt_d  = 3'd0;
                     full_d     = 1'b0;
                     state_d    = ST_TX;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_IDLE;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign sda_oe   = sda_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_req   = tx_req_q;
   assign busy     = busy_q;
   assign state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged bus master plus a transaction-level model of which bytes are ACKed, received and served.
module tb_i2c_slave;
   localparam int Q = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m;
   logic       sda_m;
   logic [7:0] tx_data;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_req;
   logic       busy;
   logic [2:0] state;
   logic       sda_bus;

   assign sda_bus = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_slave dut (
      .clk      (clk),
      .rst      (rst),
      .scl_in   (scl_m),
      .sda_in   (sda_bus),
      .sda_oe   (sda_oe),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_req   (tx_req),
      .busy     (busy),
      .state    (state)
   );

   int         tests = 0;
   int         fails = 0;
   int         tx_req_cnt = 0;
   logic [7:0] exp_rx_q[$];
   bit         may_drive = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Every-cycle compare against the model: silence when not addressed, rx bytes in order, tx_req tally.
   always @(negedge clk) begin
      if (!rst) begin
         if (!may_drive) chk("sda_oe_quiet", {31'b0, sda_oe}, 32'd0);
         if (rx_valid) begin
            if (exp_rx_q.size() == 0) chk("rx_valid_unexpected", {31'b0, rx_valid}, 32'd0);
            else chk("rx_data", {24'b0, rx_data}, {24'b0, exp_rx_q.pop_front()});
         end
         if (tx_req) tx_req_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_x(input logic b, input bit upd, input bit md, output logic r);
      sda_m = b;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      r = sda_bus;
      tick(Q);
      scl_m = 1'b0;
      if (upd) may_drive = md;
      tick(Q);
   endtask

   task automatic start_c();
      may_drive = 1'b0;
      sda_m = 1'b1;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      sda_m = 1'b0;
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
   endtask

   task automatic stop_c();
      may_drive = 1'b0;
      sda_m = 1'b0;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      sda_m = 1'b1;
      tick(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, input bit is_addr, input bit exp_ack, input string nm);
      logic r;
      for (int i = 7; i >= 0; i--) bit_x(b[i], is_addr && (i == 0), exp_ack, r);
      bit_x(1'b1, 1'b0, 1'b0, r);
      chk(nm, {31'b0, ~r}, {31'b0, exp_ack});
   endtask

   task automatic rd_byte(input bit ack, input logic [7:0] exp, input logic [7:0] nxt, input string nm);
      logic       r;
      logic [7:0] got;
      for (int i = 7; i >= 0; i--) begin
         bit_x(1'b1, 1'b0, 1'b0, r);
         got[i] = r;
      end
      tx_data = nxt;
      bit_x(~ack, 1'b0, 1'b0, r);
      chk(nm, {24'b0, got}, {24'b0, exp});
   endtask

   function automatic bit addressed(input logic [7:0] a);
      bit h;
      h = (a[7:1] == 7'h2D);
`ifdef I2C_SLAVE_GENCALL_EN
      h = h || (a == 8'h00);
`endif
      return h;
   endfunction

   // One bus transaction; data byte k is data[8k+:8], reads NACK the last byte.
   task automatic xfer(input logic [7:0] addr, input int n, input logic [39:0] data, input bit do_stop);
      bit hit;
      int txb;
      hit = addressed(addr);
      txb = tx_req_cnt;
      start_c();
      if (hit && addr[0]) tx_data = data[7:0];
      wr_byte(addr, 1'b1, hit, "addr_ack");
      chk("busy_after_addr", {31'b0, busy}, {31'b0, hit});
      for (int k = 0; k < n; k++) begin
         if (!hit) begin
            wr_byte(data[8*k +: 8], 1'b0, 1'b0, "unaddressed_nack");
         end else if (!addr[0]) begin
            exp_rx_q.push_back(data[8*k +: 8]);
            wr_byte(data[8*k +: 8], 1'b0, 1'b1, "data_ack");
         end else begin
            rd_byte(k != n - 1, data[8*k +: 8], data[8*(k+1) +: 8], "rd_data");
         end
      end
      if (do_stop) begin
         stop_c();
         tick(4);
         chk("busy_after_stop", {31'b0, busy}, 32'd0);
         chk("state_after_stop", {29'b0, state}, 32'd0);
      end
      chk("rx_all_delivered", exp_rx_q.size(), 32'd0);
      chk("tx_req_count", tx_req_cnt - txb, (hit && addr[0]) ? n : 0);
   endtask

   initial begin
      logic        r;
      logic [7:0]  a;
      logic [39:0] d;
      rst = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      tx_data = 8'h00;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("reset_sda_oe", {31'b0, sda_oe}, 32'd0);
      chk("reset_rx_data", {24'b0, rx_data}, 32'd0);
      chk("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
      chk("reset_tx_req", {31'b0, tx_req}, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_state", {29'b0, state}, 32'd0);
      tick(Q);

      // Single write
      xfer(8'h5A, 1, 40'hC3, 1'b1);
      chk("t1_rx_data", {24'b0, rx_data}, 32'h0000_00C3);
      // Single read, NACKed
      xfer(8'h5B, 1, 40'hA5, 1'b1);
      chk("t2_sda_oe", {31'b0, sda_oe}, 32'd0);
      // Burst read ACK then NACK
      xfer(8'h5B, 2, 40'h22_11, 1'b1);
      // Wrong address
      xfer(8'h40, 2, 40'h77_E1, 1'b1);

      // Repeated START after 4 data bits of a write
      start_c();
      wr_byte(8'h5A, 1'b1, 1'b1, "t5_addr_ack");
      for (int i = 0; i < 4; i++) bit_x(i[0], 1'b0, 1'b0, r);
      xfer(8'h5B, 1, 40'h3C, 1'b1);

      // Reset while the slave holds the address ACK
      start_c();
      for (int i = 7; i >= 0; i--) begin
         a = 8'h5A;
         bit_x(a[i], i == 0, 1'b1, r);
      end
      sda_m = 1'b1;
      tick(Q);
      scl_m = 1'b1;
      tick(Q);
      chk("t6_oe_before_rst", {31'b0, sda_oe}, 32'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      may_drive = 1'b0;
      chk("t6_oe_after_rst", {31'b0, sda_oe}, 32'd0);
      chk("t6_state_after_rst", {29'b0, state}, 32'd0);
      tick(Q);
      scl_m = 1'b0;
      tick(Q);
      stop_c();
      tick(Q);
      xfer(8'h00, 1, 40'h5E, 1'b1);

      // Randomized transactions against the model
      for (int t = 0; t < 18; t++) begin
         case ($urandom_range(0, 3))
            0: a = 8'h5A;
            1: a = 8'h5B;
            2: a = 8'h00;
            default: a = 8'($urandom);
         endcase
         d = {8'($urandom), 32'($urandom)};
         xfer(a, int'($urandom_range(1, 4)), d, ($urandom_range(0, 3) != 0) || (t == 17));
      end

      tick(10);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
